// File: rtl/mult_pkg.sv
// mult_pkg -- shared constants and types for the 4x4 sequential multiplier
// result path.
//   MULT_DATA_W    : product width
//   MULT_BUF_DEPTH : default result FIFO depth
//   SYNC_STAGES    : flops in a pad-strobe synchroniser
//   ACC_W          : width of the optional product accumulator
//   fifo_op_e      : what the result FIFO does on a given clock edge
package mult_pkg;

  localparam int MULT_DATA_W    = 8;
  localparam int MULT_BUF_DEPTH = 4;
  localparam int SYNC_STAGES    = 2;
  localparam int ACC_W          = 16;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/sync_rise_detect.sv
// sync_rise_detect -- STAGES-flop synchroniser for an asynchronous pad strobe,
// followed by a rising-edge detector. o_pulse is high for exactly one clk cycle
// per rising edge of the synchronised level, however long the pad stays high.
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset (all flops to 0)
//   i_async  in  asynchronous pad input
//   o_pulse  out one-cycle pulse, combinational from registers only
module sync_rise_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_pulse
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // synchroniser chain plus one flop holding the previous synchronised level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{1'b0}};
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_pulse = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/mult_result_buffer.sv
// mult_result_buffer -- captures every product the multiplier marks valid into
// a DEPTH-entry FIFO and presents the oldest entry until an external
// (asynchronous) read strobe pops it. The producer never stalls: a push into a
// full buffer is dropped and the sticky overflow flag is raised.
// Optional feature macro: MULT_BUF_ACC_EN -- when defined, acc_sum is a 16-bit
// wrapping sum of every accepted product; otherwise acc_sum is tied to zero.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   clr        in  synchronous clear (FIFO, overflow, accumulator); beats push/pop
//   in_valid   in  one-cycle strobe: in_data holds a finished product
//   in_data    in  product from the multiplier datapath
//   in_ready   out buffer can accept a push this cycle (informational)
//   rd_req     in  asynchronous pad; each rising edge pops one entry
//   out_data   out head entry, 0 when empty
//   out_valid  out buffer non-empty
//   count      out occupancy 0..DEPTH
//   overflow   out sticky: a product was dropped
//   acc_sum    out running sum of accepted products (0 without MULT_BUF_ACC_EN)
module mult_result_buffer
  import mult_pkg::*;
#(
  parameter int DEPTH  = MULT_BUF_DEPTH,
  parameter int DATA_W = MULT_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  input  logic                       rd_req,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [ACC_W-1:0]           acc_sum
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic     w_pop_pulse;
  logic     w_empty;
  logic     w_full;
  logic     w_pop;
  logic     w_push;
  logic     w_drop;
  fifo_op_e w_op;

  sync_rise_detect #(
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (rd_req),
    .o_pulse (w_pop_pulse)
  );

  assign w_empty = (r_count == CNT_W'(0));
  assign w_full  = (r_count == FULL_CNT);

  // A pop on an empty buffer is simply ignored; a pop on a full buffer frees
  // the slot the same-cycle push lands in, so a full buffer can still accept.
  assign w_pop    = w_pop_pulse & ~w_empty;
  assign in_ready = ~w_full | w_pop;
  assign w_push   = in_valid & in_ready;
  assign w_drop   = in_valid & ~in_ready;

  // classify the edge's FIFO operation
  always_comb begin
    w_op = OP_IDLE;
    if (w_push && w_pop) begin
      w_op = OP_BOTH;
    end else if (w_push) begin
      w_op = OP_PUSH;
    end else if (w_pop) begin
      w_op = OP_POP;
    end else begin
      w_op = OP_IDLE;
    end
  end

  // pointers, occupancy and sticky overflow; clr wins over push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= PTR_W'(0);
      r_rd_ptr   <= PTR_W'(0);
      r_count    <= CNT_W'(0);
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_wr_ptr   <= PTR_W'(0);
      r_rd_ptr   <= PTR_W'(0);
      r_count    <= CNT_W'(0);
      r_overflow <= 1'b0;
    end else begin
      // pointers wrap naturally because DEPTH is a power of two
      case (w_op)
        OP_PUSH: begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
          r_count  <= r_count + CNT_W'(1);
        end
        OP_POP: begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
          r_count  <= r_count - CNT_W'(1);
        end
        OP_BOTH: begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        default: begin
          r_count <= r_count;
        end
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // storage array; contents survive clr, only the pointers are reset
  always_ff @(posedge clk) begin
    if (w_push && !clr) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  assign out_valid = ~w_empty;
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : DATA_W'(0);
  assign count     = r_count;
  assign overflow  = r_overflow;

`ifdef MULT_BUF_ACC_EN
  logic [ACC_W-1:0] r_acc;

  // wrapping sum of accepted products; dropped products are never added
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= ACC_W'(0);
    end else if (clr) begin
      r_acc <= ACC_W'(0);
    end else if (w_push) begin
      r_acc <= r_acc + ACC_W'(in_data);
    end
  end

  assign acc_sum = r_acc;
`else
  assign acc_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_mult_result_buffer.sv
// Self-checking bench for mult_result_buffer: a queue-based reference model
// updated on every clock edge, an every-cycle compare on the falling edge, and
// directed scenarios with hand-computed literal expectations.
module tb_mult_result_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        rd_req = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [2:0]  count;
  logic        overflow;
  logic [15:0] acc_sum;

  int checks = 0;
  int failures = 0;

  mult_result_buffer #(
    .DEPTH  (4),
    .DATA_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .rd_req    (rd_req),
    .out_data  (out_data),
    .out_valid (out_valid),
    .count     (count),
    .overflow  (overflow),
    .acc_sum   (acc_sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Contents as a queue; rd_req samples taken at each edge (h1 newest).
  // A pop commits at edge e when rd_req was sampled high at e-2 and low at e-3.
  logic [7:0]  mq[$];
  bit          m_ovf;
  int unsigned m_acc;
  bit          h1, h2, h3;

  function automatic bit m_pulse();
    return h2 && !h3;
  endfunction

  function automatic bit m_ready();
    return (mq.size() != DEPTH) || (m_pulse() && mq.size() > 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_acc = 0;
      h1 = 1'b0;
      h2 = 1'b0;
      h3 = 1'b0;
    end else begin
      bit pop;
      bit rdy;
      pop = m_pulse() && mq.size() > 0;
      rdy = m_ready();
      if (clr) begin
        mq.delete();
        m_ovf = 1'b0;
        m_acc = 0;
      end else begin
        if (pop) void'(mq.pop_front());
        if (in_valid && rdy) begin
          mq.push_back(in_data);
`ifdef MULT_BUF_ACC_EN
          m_acc = (m_acc + in_data) % 65536;
`endif
        end
        if (in_valid && !rdy) m_ovf = 1'b1;
      end
      h3 = h2;
      h2 = h1;
      h1 = rd_req;
    end
  end

  // every-cycle compare, away from the active edge
  always @(negedge clk) begin
    logic [7:0] e_data;
    e_data = (mq.size() > 0) ? mq[0] : 8'h00;
    chk("count",     32'(count),     32'(mq.size()));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("out_data",  32'(out_data),  32'(e_data));
    chk("in_ready",  32'(in_ready),  32'(m_ready()));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("acc_sum",   32'(acc_sum),   m_acc);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic pop_seq();
    rd_req = 1'b1;
    tick(3);
    rd_req = 1'b0;
    tick(3);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  logic [7:0]  seq_full [4];
  logic [15:0] exp_acc;

  initial begin
    seq_full[0] = 8'h02;
    seq_full[1] = 8'h03;
    seq_full[2] = 8'h04;
    seq_full[3] = 8'hE1;
`ifdef MULT_BUF_ACC_EN
    exp_acc = 16'h07AC;
`else
    exp_acc = 16'h0000;
`endif

    // reset values
    tick(2);
    chk("rst_count",    32'(count),     32'd0);
    chk("rst_ready",    32'(in_ready),  32'd1);
    chk("rst_valid",    32'(out_valid), 32'd0);
    chk("rst_data",     32'(out_data),  32'h00);
    chk("rst_overflow", 32'(overflow),  32'd0);
    chk("rst_acc",      32'(acc_sum),   32'd0);
    rst_n = 1'b1;
    tick(1);

    // basic pushes
    push(8'h0F);
    push(8'h1E);
    push(8'h2D);
    chk("t1_count",    32'(count),     32'd3);
    chk("t1_data",     32'(out_data),  32'h0F);
    chk("t1_valid",    32'(out_valid), 32'd1);
    chk("t1_ready",    32'(in_ready),  32'd1);
    chk("t1_overflow", 32'(overflow),  32'd0);
    chk("t1_model",    32'(mq.size()), 32'd3);
    repeat (3) pop_seq();
    chk("t1_empty", 32'(out_valid), 32'd0);

    // fill, overflow, drain in order
    do_clr();
    for (int i = 1; i <= 4; i++) push(8'(i));
    push(8'h05);
    chk("t2_overflow", 32'(overflow), 32'd1);
    chk("t2_count",    32'(count),    32'd4);
    chk("t2_ready",    32'(in_ready), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_order", 32'(out_data), 32'(i));
      pop_seq();
    end
    chk("t2_valid",  32'(out_valid), 32'd0);
    chk("t2_sticky", 32'(overflow),  32'd1);

    // clr beats a same-cycle push
    push(8'h77);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h88;
    tick(1);
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_count",    32'(count),    32'd0);
    chk("clr_overflow", 32'(overflow), 32'd0);
    chk("clr_data",     32'(out_data), 32'h00);

    // full buffer, push in the same cycle the pop commits
    for (int i = 1; i <= 4; i++) push(8'(i));
    rd_req = 1'b1;
    tick(2);
    in_valid = 1'b1;
    in_data  = 8'hE1;
    chk("t3_ready", 32'(in_ready), 32'd1);
    tick(1);
    in_valid = 1'b0;
    chk("t3_count",    32'(count),    32'd4);
    chk("t3_overflow", 32'(overflow), 32'd0);
    rd_req = 1'b0;
    tick(3);
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", 32'(out_data), 32'(seq_full[i]));
      pop_seq();
    end

    // rd_req held high on empty buffer, push mid-hold
    rd_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) begin
        in_valid = 1'b1;
        in_data  = 8'h40;
      end
      tick(1);
      in_valid = 1'b0;
    end
    chk("t4_data",  32'(out_data), 32'h40);
    chk("t4_count", 32'(count),    32'd1);
    rd_req = 1'b0;
    tick(2);
    rd_req = 1'b1;
    tick(2);
    chk("t4_before_pop", 32'(out_valid), 32'd1);
    tick(1);
    chk("t4_after_pop", 32'(out_valid), 32'd0);
    rd_req = 1'b0;
    tick(3);

    // accumulator wrap with pops keeping up
    do_clr();
    repeat (300) begin
      push(8'hE1);
      pop_seq();
    end
    chk("t5_acc",   32'(acc_sum), 32'(exp_acc));
    chk("t5_count", 32'(count),   32'd0);
    for (int i = 1; i <= 5; i++) push(8'(i));
    chk("t5_ovf_set", 32'(overflow), 32'd1);
    do_clr();
    chk("t5_clr_acc",   32'(acc_sum),  32'd0);
    chk("t5_clr_count", 32'(count),    32'd0);
    chk("t5_clr_ovf",   32'(overflow), 32'd0);

    // asynchronous reset mid-pop, rd_req held through reset
    push(8'hAA);
    push(8'hBB);
    chk("t6_count", 32'(count), 32'd2);
    rd_req = 1'b1;
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_count", 32'(count),     32'd0);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_data",  32'(out_data),  32'h00);
    chk("t6_rst_ready", 32'(in_ready),  32'd1);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    chk("t6_post_valid", 32'(out_valid), 32'd0);
    chk("t6_post_count", 32'(count),     32'd0);
    rd_req = 1'b0;
    tick(3);
    push(8'h5A);
    tick(3);
    chk("t6_push_after", 32'(out_data), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_result_buffer.md
# mult_result_buffer

Downstream stage of the 4x4 sequential multiplier. Captures each 8-bit product the multiplier datapath marks valid, holds it in a small FIFO, and presents the oldest entry on the output pins until an external read strobe pops it. The read strobe arrives on an asynchronous pad and is synchronised and edge-detected inside the block. The multiplier does not stall, so a push into a full buffer drops the product and is flagged.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2
- DATA_W, 8, product width

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset; asynchronous, active-low
- clr  in  1  synchronous clear: empties FIFO, clears flags and accumulator
- in_valid  in  1  one-cycle strobe from multiplier control: in_data holds a finished product
- in_data  in  DATA_W  product from multiplier datapath
- in_ready  out  1  buffer can accept a push this cycle; informational only, producer does not honour it
- rd_req  in  1  asynchronous pad input; each rising edge pops one entry
- out_data  out  DATA_W  head entry; 0 when empty
- out_valid  out  1  buffer non-empty
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a product was dropped
- acc_sum  out  16  running sum of accepted products (see Configuration)

## Operation
- Reset (rst_n low, takes effect immediately): pointers 0, count 0, in_ready 1, out_valid 0, out_data 0, overflow 0, acc_sum 0, all synchroniser flops 0.
- Storage: DEPTH x DATA_W register array, write pointer and read pointer of $clog2(DEPTH) bits wrapping modulo DEPTH, separate occupancy counter.
- rd_req path: 2-flop synchroniser, then a rising-edge detector (a third flop holding the previous synchronised value). pop_pulse = sync2 & ~sync2_d. Holding rd_req high produces exactly one pop.
- pop = pop_pulse & out_valid. A pop while the buffer is empty is ignored with no flag.
- in_ready = (count != DEPTH) | pop.
- push = in_valid & in_ready. When in_valid is high and in_ready is low, the product is discarded and overflow is set.
- Simultaneous push and pop:
  - Full: both succeed and count stays at DEPTH.
  - Empty: pop is ignored and the push succeeds.
  - Otherwise: both succeed and count is unchanged.
- clr has priority over push and pop in the same cycle. Pointers, count, overflow and acc_sum go to 0. Array contents are not cleared, but out_data reads 0 while empty.
- out_data = out_valid ? mem[rd_ptr] : 0. This is combinational from registers only.
- overflow is cleared only by reset or clr.

## Timing
- Push at clock edge N: count and out_valid update after edge N. If the buffer was empty, out_data shows the new product from edge N.
- Pop latency: rd_req is first sampled high at edge k, sync2 is high after edge k+1, pop_pulse is high during the following cycle, and the pop commits at edge k+2. out_data advances after edge k+2.
- Minimum rd_req low time between pops is 2 clk periods. A narrower low is undefined.
- in_ready is combinational from registers; there is no path from in_valid or in_data to any output.
- Reset deasserted mid-operation: the block resumes empty. If rd_req is held high through reset, one pop_pulse fires two cycles after release. The buffer is empty at that point, so the pulse has no effect.

## Configuration
- MULT_BUF_ACC_EN defined: a 16-bit accumulator adds in_data, zero-extended, on every accepted push and wraps modulo 2^16. Dropped products are not added. Cleared by reset and clr.
- MULT_BUF_ACC_EN undefined: there is no accumulator logic and acc_sum is tied to 16'h0000. The port list is identical in both builds.

## Structure
- Shared package mult_pkg: MULT_DATA_W = 8, MULT_BUF_DEPTH = 4, SYNC_STAGES = 2, ACC_W = 16.
- One sub-module, sync_rise_detect: an N-stage synchroniser plus rising-edge pulse, with its own async active-low reset on clk/rst_n. It is reused later for other pad strobes.
- FIFO pointers, counter, flags and accumulator sit in the top of this block.

## Test plan
- Reset, then push 0x0F, 0x1E, 0x2D -> count=3, out_data=0x0F, out_valid=1, in_ready=1, overflow=0.
- Fill to DEPTH=4 with 0x01..0x04, then push 0x05 with no pop -> 0x05 dropped, overflow=1, count=4. After 4 pops, out_data shows 0x01..0x04 in order.
- Full buffer, push 0xE1 in the same cycle pop_pulse fires -> count stays 4 and no overflow. The entry sequence after the pop is 0x02, 0x03, 0x04, 0xE1.
- Empty buffer, raise rd_req and hold it high for 10 cycles, with a single push of 0x40 at cycle 5 -> no pop occurs and out_data=0x40 remains. Drop rd_req for 2 cycles, then raise it -> one pop on the third edge after rising, and out_valid=0.
- With MULT_BUF_ACC_EN, push 0xE1 (225) 300 times with pops keeping up -> acc_sum = 67500 mod 65536 = 1964 (0x07AC). clr -> acc_sum=0, count=0, overflow=0.
- Assert rst_n low asynchronously mid-pop with count=2 -> all outputs go to reset values before the next clk edge. After release, out_valid=0 and count=0.
